// File: rtl/trojan_chk_pkg.sv
// rtl/trojan_chk_pkg.sv - shared FSM state type, table depth and saturating increment
package trojan_chk_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} chk_state_e;

  function automatic int tbl_depth(input int n_in);
    return 1 << n_in;
  endfunction

  // Holds at 2^w-1 instead of wrapping; w must stay below 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/chk_coverage.sv
// rtl/chk_coverage.sv - seen-vector bitmap and all-covered detect
module chk_coverage
  import trojan_chk_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            clear,
  input  logic            mark,
  input  logic [N_IN-1:0] vec,
  output logic            all_seen
);

  localparam int DEPTH = tbl_depth(N_IN);

  logic [DEPTH-1:0] seen_q, seen_d, hit;

  always_comb begin
    hit      = '0;
    hit[vec] = mark;
    seen_d   = clear ? '0 : (seen_q | hit);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) seen_q <= '0;
    else       seen_q <= seen_d;
  end

  // Includes the beat being marked so the FSM can leave CHECK on the covering edge.
  assign all_seen = &(seen_q | hit);

endmodule

// File: rtl/trojan_response_checker.sv
// rtl/trojan_response_checker.sv - golden-table response checker; CHECKER_FIRST_FAIL_EN adds first_fail_vec
module trojan_response_checker
  import trojan_chk_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             ld_valid,
  input  logic [N_IN-1:0]  ld_addr,
  input  logic             ld_bit,
  input  logic             ld_last,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N_IN-1:0]  s_vec,
  input  logic             s_resp,
  output logic             busy,
  output logic             done,
  output logic             trojan,
  output logic [CNT_W-1:0] mismatch_cnt
`ifdef CHECKER_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]  first_fail_vec
`endif
);

  localparam int DEPTH = tbl_depth(N_IN);

  chk_state_e       state_q, state_d;
  logic [DEPTH-1:0] golden_q, golden_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs, mismatch, all_seen;

  // start wins over a coincident beat, which is dropped.
  assign hs       = (state_q == CHECK) && s_valid && !start;
  assign mismatch = s_resp != golden_q[s_vec];

  always_comb begin
    state_d  = state_q;
    golden_d = golden_q;
    cnt_d    = cnt_q;
    if (state_q == LOAD && ld_valid) golden_d[ld_addr] = ld_bit;
    if (start)                cnt_d = '0;
    else if (hs && mismatch)  cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    if (start) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD:    if (ld_valid && ld_last) state_d = CHECK;
        CHECK:   if (hs && all_seen)      state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      golden_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
    end
  end

  chk_coverage #(.N_IN(N_IN)) u_cov (
    .CK       (CK),
    .reset    (reset),
    .clear    (start),
    .mark     (hs),
    .vec      (s_vec),
    .all_seen (all_seen)
  );

`ifdef CHECKER_FIRST_FAIL_EN
  logic [N_IN-1:0] ffv_q, ffv_d;

  // A zero count means no mismatch yet this session; the counter never wraps back to 0.
  always_comb begin
    ffv_d = ffv_q;
    if (start)                              ffv_d = '0;
    else if (hs && mismatch && cnt_q == '0) ffv_d = s_vec;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) ffv_q <= '0;
    else       ffv_q <= ffv_d;
  end

  assign first_fail_vec = ffv_q;
`endif

  assign s_ready      = (state_q == CHECK);
  assign busy         = (state_q == LOAD) || (state_q == CHECK);
  assign done         = (state_q == DONE);
  assign trojan       = (state_q == DONE) && (cnt_q != '0);
  assign mismatch_cnt = cnt_q;

endmodule

// File: doc/trojan_response_checker.md
# trojan_response_checker

Synthesizable response checker for the Trojan-detection benchmark flow. It receives (input vector, circuit response) pairs and compares each pair against a golden truth table loaded beforehand. It tracks which of the 2^N_IN vectors have been exercised and reports a detect verdict once every vector has been checked. It is the on-chip consumer of the exhaustive vector/response sequence that our benches generate and dump per benchmark.

## Interface
Parameters:
- N_IN, 3, width of the input vector under test; the golden table holds 2^N_IN entries.
- CNT_W, 8, width of the mismatch counter; the counter saturates at 2^CNT_W−1.

Ports:
- CK  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that opens a new session.
- ld_valid  in  1  golden-table write strobe; acted on only in LOAD.
- ld_addr  in  N_IN  golden-table index.
- ld_bit  in  1  golden response for ld_addr.
- ld_last  in  1  marks the final load beat; qualified by ld_valid.
- s_valid  in  1  response beat valid.
- s_ready  out  1  checker can accept a response beat.
- s_vec  in  N_IN  applied input vector.
- s_resp  in  1  observed circuit response.
- busy  out  1  state is LOAD or CHECK.
- done  out  1  all vectors covered; verdict is valid.
- trojan  out  1  mismatch_cnt ≠ 0; valid while done=1.
- mismatch_cnt  out  CNT_W  saturating count of mismatching beats.
- first_fail_vec  out  N_IN  first mismatching vector; present only with the macro enabled.

## Operation
- FSM states: IDLE, LOAD, CHECK, DONE. Reset state is IDLE.
- start in any state: clears mismatch_cnt, the coverage bitmap and first_fail_vec, and moves to LOAD. The golden table is not cleared.
- LOAD: each ld_valid beat writes golden[ld_addr] = ld_bit. ld_valid && ld_last writes that beat, then moves to CHECK. Unwritten entries keep their previous value (0 after reset).
- CHECK: s_ready = 1. A handshake is s_valid && s_ready. On a handshake:
  - compute mismatch = s_resp ≠ golden[s_vec];
  - on a mismatch, increment mismatch_cnt, saturating at all-ones;
  - set seen[s_vec].
- Duplicate vectors are compared and counted again; coverage is unchanged.
- When seen, including the current beat, becomes all ones, move to DONE.
- DONE: s_ready = 0 and done = 1; the verdict holds until start or reset.
- IDLE: s_ready = 0. ld_valid and s_valid are ignored in IDLE and DONE.
- ld_valid is ignored outside LOAD; s_valid is ignored outside CHECK.

## Timing
- Reset values: state IDLE; s_ready, busy, done, trojan = 0; mismatch_cnt = 0; first_fail_vec = 0; golden and seen all 0.
- All outputs are registered or decoded from registered state. No combinational path exists from inputs to outputs.
- mismatch_cnt updates on the edge that completes a handshake, so it is visible the following cycle.
- done and trojan assert in the cycle after the covering handshake. Throughput is one beat per cycle.
- A start coincident with a handshake: start wins, the beat is dropped, and the next state is LOAD.
- A start coincident with ld_valid in LOAD: the state restarts LOAD, and the beat is written.
- Asserting reset mid-session aborts the session immediately and returns to the reset values.

## Configuration
- CHECKER_FIRST_FAIL_EN defined:
  - first_fail_vec is a register that captures s_vec on the first mismatch of a session;
  - it holds that value until start or reset.
- CHECKER_FIRST_FAIL_EN undefined: the first_fail_vec port and its register are absent.

## Structure
- Package trojan_chk_pkg holds:
  - the FSM state enum (IDLE, LOAD, CHECK, DONE);
  - a localparam function for the table depth 2^N_IN;
  - the saturating-increment helper.
- Sub-module chk_coverage holds the seen bitmap and the all-covered detect. Its inputs are clear, mark, vec; its output is all_seen.

## Test plan
- Default parameters, golden = 8'b1001_0110, responses matching for vectors 0..7 in order -> done one cycle after the 8th beat; trojan = 0; mismatch_cnt = 0.
- Same golden, vector 5 response flipped -> trojan = 1; mismatch_cnt = 1; first_fail_vec = 5 (macro on).
- Vectors sent 0,1,1,2..7 with a mismatch on the second 1 -> done after 9 beats; mismatch_cnt = 1.
- Reset asserted after 4 beats -> s_ready = 0, mismatch_cnt = 0, state IDLE. A new start plus a full load and check completes normally.
- CNT_W = 2, 5 mismatching beats -> mismatch_cnt saturates at 3.
- s_valid held high in IDLE and DONE -> no count change and s_ready stays 0. start coincident with a handshake -> the beat is dropped.
